la_acq: RTL and testbench
=========================

# la_acq

Logic-analyzer acquisition block: the receive-side counterpart of the logic generator. It samples a DW-bit digital input stream and runs a pre-trigger / wait-for-trigger / post-trigger acquisition sequence. Triggering is on a masked level pattern combined with an optional edge condition. Accepted samples are forwarded to a buffer-writer stream, with TLAST on the final post-trigger sample. It sits between the digital-input synchronizer stream and the acquisition buffer DMA.

## Interface
Parameters:
- DW, 16, sample width in bits (one bit per digital pin)
- CW, 32, width of the pre/post counters and status counters

Ports:
- clk  in  1  clock for all logic
- rst  in  1  synchronous, active-high reset
- ctl_arm  in  1  single-cycle pulse; starts an acquisition from IDLE
- ctl_stp  in  1  single-cycle pulse; aborts the acquisition
- ctl_swt  in  1  single-cycle pulse; software trigger
- cfg_msk  in  DW  level-compare mask (1 = bit participates)
- cfg_val  in  DW  level-compare value
- cfg_edp  in  DW  rising-edge select
- cfg_edn  in  DW  falling-edge select
- cfg_pre  in  CW  minimum number of samples before a trigger is accepted
- cfg_pst  in  CW  number of samples after the trigger sample
- sti_tdata  in  DW  input sample
- sti_tvalid  in  1  input valid
- sti_tready  out  1  input ready
- sto_tdata  out  DW  output sample
- sto_tvalid  out  1  output valid
- sto_tready  in  1  output ready
- sto_tlast  out  1  marks the last sample of the acquisition
- sts_run  out  1  high in any state other than IDLE
- sts_trg  out  1  trigger has occurred in the current or last acquisition
- sts_pre  out  CW  samples forwarded before the trigger (saturating)
- sts_pst  out  CW  samples forwarded from the trigger sample onward
- trg_out  out  1  one-cycle pulse on trigger (to the scope/generator)
- irq  out  1  one-cycle pulse on normal completion

## Operation
- The FSM has four states: IDLE, PRE, ARM, POST.
- IDLE:
  - sti_tready=1; samples are discarded.
  - ctl_arm moves the FSM to PRE, or directly to ARM if cfg_pre==0.
  - ctl_arm also clears sts_trg, sts_pre and sts_pst.
- PRE: forwards samples. Triggers are ignored. The FSM moves to ARM once the cfg_pre-th sample has been forwarded.
- ARM: forwards samples. The first accepted sample that satisfies the trigger is the trigger sample. On the trigger sample the FSM moves to POST and sets sts_trg.
- POST: forwards samples. The beat that completes cfg_pst+1 samples from the trigger sample carries sto_tlast=1; the FSM then returns to IDLE.
- Trigger condition on an accepted sample d, with prev = previously accepted sample:
  - lvl = ((d ^ cfg_val) & cfg_msk) == 0
  - edg = |((~prev & d & cfg_edp) | (prev & ~d & cfg_edn))
  - trigger = lvl & (edg | (cfg_edp|cfg_edn)==0)
  - ctl_swt in ARM forces a trigger on the next accepted sample.
- prev updates on every accepted sample in every state, including IDLE. It resets to 0.
- sts_pre counts forwarded samples in PRE and ARM and saturates at 2^CW-1. sts_pst counts forwarded samples in POST, including the trigger sample.
- ctl_stp in any non-IDLE state moves the FSM to IDLE with no TLAST and no irq. A beat already held on sto remains valid until it is accepted.
- Simultaneous events:
  - ctl_stp and ctl_arm in the same cycle: stop wins.
  - ctl_arm while not in IDLE is ignored.
  - A trigger on the last PRE sample is ignored.
- cfg_* must be stable while sts_run=1. Changes made while running are undefined in effect.

## Timing
- The output stage is a single register slice. sti_tready = ~sto_tvalid | sto_tready when running.
- Latency is 1 cycle from sti handshake to sto_tvalid.
- AXI rules: sto_tvalid and sto_tdata/sto_tlast hold until sto_tready. No combinational path from sto_tready to sto_tvalid.
- trg_out pulses in the cycle after the trigger sample is accepted on sti.
- irq pulses in the cycle after the TLAST beat handshakes on sto.
- sts_run drops in the cycle after the TLAST beat is accepted on sti.
- On reset, all outputs are 0 from the next cycle: state IDLE, prev cleared, output slice emptied. This applies also mid-acquisition.

## Configuration
- LA_DECIMATION_EN:
  - When defined, adds input port cfg_dec (CW bits). Only every (cfg_dec+1)-th accepted sample is evaluated for trigger, counted and forwarded. The decimation counter restarts on ctl_arm. prev tracks decimated samples only.
  - When undefined, the port is absent and every sample is used.

## Test plan
- Level trigger: cfg_msk=0x00FF, cfg_val=0x0042, cfg_pre=4, cfg_pst=3; input a ramp 0x0000,0x0001,… -> trigger on 0x0042; sto carries 0x0000…0x0045 with TLAST on 0x0045; sts_pre=0x42, sts_pst=4; one irq pulse.
- Edge trigger: cfg_edp=0x0001, cfg_msk=0, input toggling bit0 starting from 0 -> trigger on the first 0→1 sample after PRE completes; trg_out one cycle later.
- Backpressure: random sto_tready at 30% duty -> no lost or duplicated samples, tdata held stable while stalled, and the TLAST position is unchanged.
- Abort: ctl_stp issued in ARM after 10 samples -> FSM returns to IDLE, no TLAST, no irq, sts_trg=0; ctl_stp and ctl_arm together in IDLE leave the FSM in IDLE.
- Boundaries: cfg_pre=0, cfg_pst=0 with ctl_swt -> exactly one output beat carrying TLAST; sts_pre saturates with CW=4 and a long ARM wait.
- Reset: rst asserted during POST -> next cycle sts_run=0, sto_tvalid=0, all outputs 0; a fresh ctl_arm acquires normally.

Source files
------------

// File: rtl/la_acq_if.sv
// rtl/la_acq_if.sv - sample stream interface for the logic-analyzer acquisition block
//
// Purpose: one handshaked sample stream (input from the pin synchronizer or
// output to the buffer writer).
// Signals:
//   tdata  DW  sample, one bit per digital pin
//   tvalid 1   sample valid
//   tready 1   sink ready
//   tlast  1   final sample of an acquisition
// Modports: master drives tdata/tvalid/tlast, slave drives tready.

interface la_acq_if #(
  parameter int DW = 16
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/la_acq.sv
// rtl/la_acq.sv - logic-analyzer acquisition: pre/arm/post sequencing with pattern and edge trigger
//
// Purpose: samples a DW-bit digital input stream, forwards a pre-trigger
// window, waits for a masked level / edge trigger (or a software trigger),
// then forwards cfg_pst more samples and closes the acquisition with tlast.
// Optional build macro: LA_DECIMATION_EN adds cfg_dec; only every
// (cfg_dec+1)-th accepted input sample is then used.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ctl_arm/ctl_stp/ctl_swt  start, abort, software-trigger pulses
//   cfg_msk/cfg_val          level compare mask and value
//   cfg_edp/cfg_edn          rising / falling edge select per pin
//   cfg_pre/cfg_pst          pre-trigger minimum, post-trigger sample count
//   cfg_dec                  decimation ratio minus one (LA_DECIMATION_EN only)
//   sti                      input sample stream (slave)
//   sto                      output sample stream to the buffer writer (master)
//   sts_run/sts_trg          running flag, trigger-seen flag
//   sts_pre/sts_pst          forwarded sample counts before / from the trigger
//   trg_out, irq             trigger pulse, completion pulse

module la_acq #(
  parameter int DW = 16,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctl_arm,
  input  logic          ctl_stp,
  input  logic          ctl_swt,
  input  logic [DW-1:0] cfg_msk,
  input  logic [DW-1:0] cfg_val,
  input  logic [DW-1:0] cfg_edp,
  input  logic [DW-1:0] cfg_edn,
  input  logic [CW-1:0] cfg_pre,
  input  logic [CW-1:0] cfg_pst,
`ifdef LA_DECIMATION_EN
  input  logic [CW-1:0] cfg_dec,
`endif
  la_acq_if.slave       sti,
  la_acq_if.master      sto,
  output logic          sts_run,
  output logic          sts_trg,
  output logic [CW-1:0] sts_pre,
  output logic [CW-1:0] sts_pst,
  output logic          trg_out,
  output logic          irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_ARM  = 2'd2,
    ST_POST = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [DW-1:0] prev;
  logic          swt_pend;

  // Output register slice
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;

  logic          running;
  logic          accept;
  logic          use_smp;
  logic          stop;
  logic          arm_go;

  logic          lvl;
  logic          edg;
  logic          no_edge;
  logic          hit;

  logic          fwd;
  logic          fwd_last;
  logic          trig;
  logic          pre_inc;
  logic          pst_inc;

  assign running = (state != ST_IDLE);

  // Idle discards samples, so it always accepts. While running, a new
  // sample is taken only if the slice is empty or draining this cycle.
  assign sti.tready = running ? (~out_valid | sto.tready) : 1'b1;
  assign accept     = sti.tvalid & sti.tready;

`ifdef LA_DECIMATION_EN
  logic [CW-1:0] dec_cnt;

  assign use_smp = accept & (dec_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt <= '0;
    end else if (arm_go) begin
      dec_cnt <= '0;
    end else if (accept) begin
      dec_cnt <= (dec_cnt >= cfg_dec) ? '0 : dec_cnt + CW'(1);
    end
  end
`else
  assign use_smp = accept;
`endif

  assign stop   = ctl_stp & running;
  // Stop wins over a simultaneous arm.
  assign arm_go = (state == ST_IDLE) & ctl_arm & ~ctl_stp;

  // Trigger evaluation on the current input sample against the last used one.
  assign lvl     = (((sti.tdata ^ cfg_val) & cfg_msk) == '0);
  assign edg     = |((~prev & sti.tdata & cfg_edp) | (prev & ~sti.tdata & cfg_edn));
  assign no_edge = ((cfg_edp | cfg_edn) == '0);
  assign hit     = lvl & (edg | no_edge);

  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    fwd_last  = 1'b0;
    trig      = 1'b0;
    pre_inc   = 1'b0;
    pst_inc   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (arm_go) begin
          state_nxt = (cfg_pre == '0) ? ST_ARM : ST_PRE;
        end
      end

      ST_PRE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (use_smp) begin
          fwd     = 1'b1;
          pre_inc = 1'b1;
          // sts_pre cannot saturate before reaching cfg_pre-1, so it
          // doubles as the pre-window counter. Triggers are not looked at.
          if (sts_pre == (cfg_pre - CW'(1))) begin
            state_nxt = ST_ARM;
          end
        end
      end

      ST_ARM: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (use_smp) begin
          fwd = 1'b1;
          if (hit | swt_pend | ctl_swt) begin
            trig    = 1'b1;
            pst_inc = 1'b1;
            if (cfg_pst == '0) begin
              fwd_last  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_POST;
            end
          end else begin
            pre_inc = 1'b1;
          end
        end
      end

      ST_POST: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (use_smp) begin
          fwd     = 1'b1;
          pst_inc = 1'b1;
          // sts_pst already includes the trigger sample, so reaching
          // cfg_pst here means this beat is sample cfg_pst+1.
          if (sts_pst == cfg_pst) begin
            fwd_last  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      swt_pend <= 1'b0;
      sts_trg  <= 1'b0;
      sts_pre  <= '0;
      sts_pst  <= '0;
      trg_out  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (use_smp) begin
        prev <= sti.tdata;
      end

      // A software trigger waits for the next used sample; it only lives in ARM.
      swt_pend <= (state == ST_ARM) & ~stop & ~trig & (swt_pend | ctl_swt);

      if (arm_go) begin
        sts_trg <= 1'b0;
        sts_pre <= '0;
        sts_pst <= '0;
      end else begin
        if (pre_inc && (sts_pre != '1)) begin
          sts_pre <= sts_pre + CW'(1);
        end
        if (pst_inc) begin
          sts_pst <= sts_pst + CW'(1);
        end
        if (trig) begin
          sts_trg <= 1'b1;
        end
      end

      trg_out <= trig;
      irq     <= out_valid & sto.tready & out_last;
    end
  end

  // Register slice. A beat left in the slice after a stop still drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (fwd) begin
      out_valid <= 1'b1;
      out_data  <= sti.tdata;
      out_last  <= fwd_last;
    end else if (sto.tready) begin
      out_valid <= 1'b0;
    end
  end

  assign sto.tvalid = out_valid;
  assign sto.tdata  = out_data;
  assign sto.tlast  = out_last;
  assign sts_run    = running;

endmodule

// File: tb/tb_la_acq.sv
// tb/tb_la_acq.sv - directed self-checking bench for la_acq

module tb_la_acq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctl_arm, ctl_stp, ctl_swt;
  logic [15:0] cfg_msk, cfg_val, cfg_edp, cfg_edn;
  logic [31:0] cfg_pre, cfg_pst;
  logic        sts_run, sts_trg, trg_out, irq;
  logic [31:0] sts_pre, sts_pst;

  logic [3:0]  cfg_pre4, cfg_pst4;
  logic        sts_run4, sts_trg4, trg_out4, irq4;
  logic [3:0]  sts_pre4, sts_pst4;

  la_acq_if #(.DW(16)) sti_if ();
  la_acq_if #(.DW(16)) sto_if ();
  la_acq_if #(.DW(16)) s4_in ();
  la_acq_if #(.DW(16)) s4_out ();

  always #5 clk = ~clk;

  la_acq #(.DW(16), .CW(32)) dut (
    .clk(clk), .rst(rst),
    .ctl_arm(ctl_arm), .ctl_stp(ctl_stp), .ctl_swt(ctl_swt),
    .cfg_msk(cfg_msk), .cfg_val(cfg_val), .cfg_edp(cfg_edp), .cfg_edn(cfg_edn),
    .cfg_pre(cfg_pre), .cfg_pst(cfg_pst),
    .sti(sti_if), .sto(sto_if),
    .sts_run(sts_run), .sts_trg(sts_trg), .sts_pre(sts_pre), .sts_pst(sts_pst),
    .trg_out(trg_out), .irq(irq)
  );

  // Narrow-counter instance for the saturation check; it follows the main input.
  assign s4_in.tdata   = sti_if.tdata;
  assign s4_in.tvalid  = sti_if.tvalid;
  assign s4_in.tlast   = 1'b0;
  assign s4_out.tready = 1'b1;

  la_acq #(.DW(16), .CW(4)) dut4 (
    .clk(clk), .rst(rst),
    .ctl_arm(ctl_arm), .ctl_stp(ctl_stp), .ctl_swt(ctl_swt),
    .cfg_msk(cfg_msk), .cfg_val(cfg_val), .cfg_edp(cfg_edp), .cfg_edn(cfg_edn),
    .cfg_pre(cfg_pre4), .cfg_pst(cfg_pst4),
    .sti(s4_in), .sto(s4_out),
    .sts_run(sts_run4), .sts_trg(sts_trg4), .sts_pre(sts_pre4), .sts_pst(sts_pst4),
    .trg_out(trg_out4), .irq(irq4)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // Monitor state
  logic [16:0] got_q[$];
  logic [15:0] exp_q[$];
  int          trg_cnt, irq_cnt, irq_bad, stall_bad;
  logic [15:0] trg_data;
  logic        p_sti_hs, p_sto_last_hs, p_stall, p_last;
  logic [15:0] p_sti_data, p_data;
  bit          bp = 0;

  initial begin
    p_sti_hs = 0; p_sto_last_hs = 0; p_stall = 0; p_last = 0;
    p_sti_data = 0; p_data = 0;
  end

  always @(negedge clk) begin
    if (trg_out) begin
      trg_cnt++;
      trg_data = p_sti_hs ? p_sti_data : 16'hdead;
    end
    if (irq) begin
      irq_cnt++;
      if (!p_sto_last_hs) irq_bad++;
    end
    if (p_stall && (!sto_if.tvalid || sto_if.tdata !== p_data || sto_if.tlast !== p_last))
      stall_bad++;
    if (sto_if.tvalid && sto_if.tready) got_q.push_back({sto_if.tlast, sto_if.tdata});
    p_sti_hs      = sti_if.tvalid && sti_if.tready;
    p_sti_data    = sti_if.tdata;
    p_sto_last_hs = sto_if.tvalid && sto_if.tready && sto_if.tlast;
    p_stall       = sto_if.tvalid && !sto_if.tready;
    p_data        = sto_if.tdata;
    p_last        = sto_if.tlast;
  end

  always @(posedge clk) begin
    #1;
    sto_if.tready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    trg_cnt = 0; irq_cnt = 0; irq_bad = 0; stall_bad = 0; trg_data = 16'h0;
  endtask

  // All driving tasks start and end at posedge+1.
  task automatic pulse(input logic a, input logic s, input logic w);
    ctl_arm = a; ctl_stp = s; ctl_swt = w;
    @(posedge clk); #1;
    ctl_arm = 0; ctl_stp = 0; ctl_swt = 0;
  endtask

  task automatic send(input logic [15:0] d);
    int t = 0;
    bit ok = 0;
    sti_if.tdata  = d;
    sti_if.tvalid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = sti_if.tready;
      @(posedge clk); #1;
      t++;
    end
    sti_if.tvalid = 1'b0;
    if (!ok) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sts_run || sto_if.tvalid) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) chk("idle_timeout", 64'(0), 64'(1));
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic cmp_out(input string tag, input bit want_last);
    int errs = 0;
    int n;
    chk({tag, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_q[i][15:0] !== exp_q[i]) errs++;
      if (got_q[i][16] !== (want_last && (i == exp_q.size() - 1))) errs++;
    end
    chk({tag, "_data"}, 64'(errs), 64'(0));
  endtask

  task automatic run_level(input string tag);
    cfg_msk = 16'h00FF; cfg_val = 16'h0042; cfg_edp = 0; cfg_edn = 0;
    cfg_pre = 4; cfg_pst = 3;
    clear_mon();
    for (int i = 0; i <= 'h45; i++) exp_q.push_back(16'(i));
    pulse(1, 0, 0);
    @(negedge clk);
    chk({tag, "_run_after_arm"}, 64'(sts_run), 64'(1));
    @(posedge clk); #1;
    for (int i = 0; i <= 'h45; i++) send(16'(i));
    wait_idle();
    cmp_out(tag, 1);
    chk({tag, "_sts_pre"}, 64'(sts_pre), 64'h42);
    chk({tag, "_sts_pst"}, 64'(sts_pst), 64'h4);
    chk({tag, "_sts_trg"}, 64'(sts_trg), 64'(1));
    chk({tag, "_trg_cnt"}, 64'(trg_cnt), 64'(1));
    chk({tag, "_trg_sample"}, 64'(trg_data), 64'h42);
    chk({tag, "_irq_cnt"}, 64'(irq_cnt), 64'(1));
    chk({tag, "_irq_timing"}, 64'(irq_bad), 64'(0));
    chk({tag, "_stall_hold"}, 64'(stall_bad), 64'(0));
    chk({tag, "_run_end"}, 64'(sts_run), 64'(0));
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_run"}, 64'(sts_run), 64'(0));
    chk({tag, "_tvalid"}, 64'(sto_if.tvalid), 64'(0));
    chk({tag, "_tdata"}, 64'(sto_if.tdata), 64'(0));
    chk({tag, "_tlast"}, 64'(sto_if.tlast), 64'(0));
    chk({tag, "_trg"}, 64'(sts_trg), 64'(0));
    chk({tag, "_pre"}, 64'(sts_pre), 64'(0));
    chk({tag, "_pst"}, 64'(sts_pst), 64'(0));
    chk({tag, "_trg_out"}, 64'(trg_out), 64'(0));
    chk({tag, "_irq"}, 64'(irq), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; ctl_arm = 0; ctl_stp = 0; ctl_swt = 0;
    cfg_msk = 0; cfg_val = 0; cfg_edp = 0; cfg_edn = 0; cfg_pre = 0; cfg_pst = 0;
    cfg_pre4 = 1; cfg_pst4 = 0;
    sti_if.tdata = 0; sti_if.tvalid = 0; sti_if.tlast = 0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check_zero("reset");

    // Level trigger on a ramp
    run_level("level");

    // Edge trigger: bit0 toggles from 0, upper bits carry the index
    cfg_msk = 0; cfg_val = 0; cfg_edp = 16'h0001; cfg_edn = 0;
    cfg_pre = 4; cfg_pst = 2;
    clear_mon();
    for (int i = 0; i < 8; i++) exp_q.push_back(16'((i << 1) | (i & 1)));
    pulse(1, 0, 0);
    for (int i = 0; i < 10; i++) send(16'((i << 1) | (i & 1)));
    wait_idle();
    cmp_out("edge", 1);
    chk("edge_trg_sample", 64'(trg_data), 64'h000B);
    chk("edge_trg_cnt", 64'(trg_cnt), 64'(1));
    chk("edge_sts_pre", 64'(sts_pre), 64'(5));
    chk("edge_sts_pst", 64'(sts_pst), 64'(3));
    chk("edge_irq_cnt", 64'(irq_cnt), 64'(1));

    // Backpressure: same ramp with random output stalls
    bp = 1;
    run_level("bp");
    bp = 0;
    @(posedge clk); #1;

    // Abort in ARM after 10 samples
    cfg_msk = 16'hFFFF; cfg_val = 16'hFFFF; cfg_edp = 0; cfg_edn = 0;
    cfg_pre = 2; cfg_pst = 0;
    clear_mon();
    for (int i = 0; i < 12; i++) exp_q.push_back(16'(i + 16'h100));
    pulse(1, 0, 0);
    for (int i = 0; i < 12; i++) send(16'(i + 16'h100));
    repeat (3) begin @(posedge clk); #1; end
    pulse(0, 1, 0);
    wait_idle();
    cmp_out("abort", 0);
    chk("abort_run", 64'(sts_run), 64'(0));
    chk("abort_sts_trg", 64'(sts_trg), 64'(0));
    chk("abort_irq_cnt", 64'(irq_cnt), 64'(0));
    chk("abort_sts_pre", 64'(sts_pre), 64'(12));
    pulse(1, 1, 0);
    @(negedge clk);
    chk("stp_arm_run", 64'(sts_run), 64'(0));
    chk("stp_arm_pre_kept", 64'(sts_pre), 64'(12));
    @(posedge clk); #1;

    // Boundary: no pre window, single post sample, software trigger
    cfg_pre = 0; cfg_pst = 0;
    clear_mon();
    exp_q.push_back(16'h1234);
    pulse(1, 0, 0);
    @(negedge clk);
    chk("swt_run", 64'(sts_run), 64'(1));
    @(posedge clk); #1;
    pulse(0, 0, 1);
    send(16'h1234);
    send(16'h1235);
    send(16'h1236);
    wait_idle();
    cmp_out("swt", 1);
    chk("swt_sts_pre", 64'(sts_pre), 64'(0));
    chk("swt_sts_pst", 64'(sts_pst), 64'(1));
    chk("swt_trg_sample", 64'(trg_data), 64'h1234);
    chk("swt_irq_cnt", 64'(irq_cnt), 64'(1));

    // Saturation with CW=4 during a long ARM wait
    pulse(0, 1, 0);
    cfg_pre = 1; cfg_pre4 = 1;
    pulse(1, 0, 0);
    for (int i = 0; i < 20; i++) send(16'(i));
    @(negedge clk);
    chk("sat_main_pre", 64'(sts_pre), 64'(20));
    chk("sat_cw4_pre", 64'(sts_pre4), 64'hF);
    chk("sat_cw4_run", 64'(sts_run4), 64'(1));
    @(posedge clk); #1;
    pulse(0, 1, 0);
    wait_idle();

    // Reset during POST, then a fresh acquisition
    cfg_msk = 16'h00FF; cfg_val = 16'h0042; cfg_pre = 4; cfg_pst = 3;
    pulse(1, 0, 0);
    for (int i = 0; i <= 'h43; i++) send(16'(i));
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check_zero("midrst");
    run_level("fresh");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
